// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
// Imported by div_step and binary_divider.
package div_pkg;

  localparam int N_DEF = 4;
  localparam int CW_DEF = $clog2(2 * N_DEF);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic int cnt_w(input int n);
    return (2 * n > 1) ? $clog2(2 * n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Purely combinational; the top registers R and Q each cycle.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0]   r,
  input  logic [2*N-1:0] q,
  input  logic [N-1:0]   d,
  output logic [N-1:0]   r_nx,
  output logic [2*N-1:0] q_nx
);

  logic [N:0] t;
  logic [N:0] diff;
  logic       ge;

  // N+1 bit compare so the shifted-in bit never overflows R
  assign t    = {r, q[2*N-1]};
  assign diff = t - {1'b0, d};
  assign ge   = t >= {1'b0, d};

  assign r_nx = ge ? diff[N-1:0] : t[N-1:0];
  assign q_nx = {q[2*N-2:0], ge};

endmodule

// File: rtl/binary_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock with IDLE/CALC/DONE control.
module binary_divider
  import div_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quot,
  output logic [N-1:0]   rem,
  output logic           dbz
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  div_state_t     state;
  div_state_t     nstate;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   r_q;
  logic [2*N-1:0] q_q;
  logic [N-1:0]   d_q;
  logic           dbz_q;
  logic [N-1:0]   r_nx;
  logic [2*N-1:0] q_nx;
  logic           acc;
  logic           dz;

  div_step #(
    .N(N)
  ) u_step (
    .r   (r_q),
    .q   (q_q),
    .d   (d_q),
    .r_nx(r_nx),
    .q_nx(q_nx)
  );

  assign acc = ld && (state != CALC);
  assign dz  = (divisor == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (ld) nstate = dz ? DONE : CALC;
      end
      CALC: begin
        if (cnt == LAST) nstate = DONE;
      end
      DONE: begin
        if (ld) nstate = dz ? DONE : CALC;
        else    nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      dbz_q <= 1'b0;
    end else begin
      unique case (1'b1)
        acc && dz: begin
          q_q   <= '1;
          r_q   <= '0;
          cnt   <= '0;
          dbz_q <= 1'b1;
        end
        acc && !dz: begin
          q_q   <= dividend;
          r_q   <= '0;
          d_q   <= divisor;
          cnt   <= '0;
          dbz_q <= 1'b0;
        end
        state == CALC: begin
          q_q <= q_nx;
          r_q <= r_nx;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign quot = q_q;
  assign rem  = r_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_binary_divider.sv
// Directed and exhaustive-sweep bench for binary_divider, N=4.
// Expected values are hand-computed or derived from / and %.
module tb_binary_divider;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic           ld;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quot;
  logic [N-1:0]   rem;
  logic           dbz;

  int nchk;
  int nerr;

  binary_divider #(
    .N(N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ld      (ld),
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .quot    (quot),
    .rem     (rem),
    .dbz     (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int l0, output int lat, output int bc,
                           output bit both);
    lat  = l0;
    bc   = 0;
    both = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      lat++;
      if (busy && done) both = 1;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] dd,
                     input logic [3:0] dv, input int elat,
                     input logic [7:0] eq, input logic [3:0] er,
                     input logic edbz);
    int lat;
    int bc;
    bit both;
    dividend = dd;
    divisor  = dv;
    ld       = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    wait_done(1, lat, bc, both);
    check({tag, " lat"}, lat, elat);
    check({tag, " quot"}, quot, eq);
    check({tag, " rem"}, rem, er);
    check({tag, " dbz"}, dbz, edbz);
    check({tag, " busycyc"}, bc, elat - 1);
    check({tag, " busy&done"}, both, 0);
    @(posedge clk);
    #1;
    check({tag, " donepulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int bc;
    bit both;
    bit seen;
    nchk     = 0;
    nerr     = 0;
    rst      = 1'b0;
    ld       = 1'b0;
    dividend = '0;
    divisor  = '0;
    #2;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst quot", quot, 0);
    check("rst rem", rem, 0);
    check("rst dbz", dbz, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run("200/7", 8'd200, 4'd7, 9, 8'd28, 4'd4, 1'b0);
    run("255/1", 8'd255, 4'd1, 9, 8'd255, 4'd0, 1'b0);
    run("5/9", 8'd5, 4'd9, 9, 8'd0, 4'd5, 1'b0);
    run("0/15", 8'd0, 4'd15, 9, 8'd0, 4'd0, 1'b0);
    run("77/0", 8'd77, 4'd0, 1, 8'hFF, 4'd0, 1'b1);
    run("77/11", 8'd77, 4'd11, 9, 8'd7, 4'd0, 1'b0);

    // ld during CALC must be ignored
    dividend = 8'd200;
    divisor  = 4'd7;
    ld       = 1'b1;
    @(posedge clk);
    #1;
    ld  = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dividend = 8'd100;
    divisor  = 4'd3;
    ld       = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    ld = 1'b0;
    wait_done(lat, lat, bc, both);
    check("ign lat", lat, 9);
    check("ign quot", quot, 28);
    check("ign rem", rem, 4);
    @(posedge clk);
    #1;

    // asynchronous reset during CALC step 3
    dividend = 8'd200;
    divisor  = 4'd7;
    ld       = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("pre-rst busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst quot", quot, 0);
    check("arst rem", rem, 0);
    check("arst dbz", dbz, 0);
    #2;
    rst  = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    check("arst nodone", seen, 0);
    run("143/13", 8'd143, 4'd13, 9, 8'd11, 4'd0, 1'b0);

    // all 2^12 pairs in scrambled order, ld held high
    ld = 1'b1;
    for (int p = 0; p < 4096; p++) begin
      int idx;
      logic [7:0] dd;
      logic [3:0] dv;
      logic [20:0] exp;
      logic [4:0] l5;
      idx = (p * 2731) % 4096;
      dd  = idx[11:4];
      dv  = idx[3:0];
      dividend = dd;
      divisor  = dv;
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        lat++;
      end while (!done && lat < 30);
      if (dv == 0) exp = {5'd1, 1'b1, 4'd0, 8'hFF};
      else exp = {5'd9, 1'b0, 4'(dd % dv), 8'(dd / dv)};
      l5 = 5'(lat);
      check($sformatf("sweep %0d/%0d", dd, dv),
            {11'd0, l5, dbz, rem, quot}, {11'd0, exp});
    end
    ld = 1'b0;
    @(posedge clk);
    #1;
    check("sweep idle", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
